// File: rtl/fifo_ext_pkg.sv
// rtl/fifo_ext_pkg.sv - shared mode constants, output-stage state type and helpers for fifo_ext
package fifo_ext_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Output register occupancy, only meaningful in first-word-fall-through mode
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    // Index width for a 0..depth-1 counter; at least one bit
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping index counter 0..DEPTH-1 for fifo read/write pointers
module fifo_ptr
    import fifo_ext_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] idx
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Advance on inc; wrap by explicit compare so non-power-of-two depths work
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx <= '0;
        end else if (inc) begin
            idx <= (idx == LAST) ? '0 : idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_ext.sv
// rtl/fifo_ext.sv - parametrised synchronous FIFO with FWFT option, occupancy and sticky error flags
module fifo_ext
    import fifo_ext_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     din,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    out_state_t state;
    out_state_t state_nxt;

    logic wr_ok;
    logic rd_ok;
    logic mem_we;
    logic rd_inc;
    logic load_mem;
    logic load_din;
    logic stor_empty;
    logic [CNT_WIDTH-1:0] held;

    // Flags depend only on the registered count
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // In FWFT mode the output register holds one of the counted words
    assign held       = (state == OUT_VALID) ? CNT_WIDTH'(1) : '0;
    assign stor_empty = (count == held);

    fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (mem_we),
        .idx (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_inc),
        .idx (rd_ptr)
    );

    // Output-stage state register (stays OUT_EMPTY in standard mode)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Decide where accepted words go and what loads the output register
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        rd_inc    = 1'b0;
        load_mem  = 1'b0;
        load_din  = 1'b0;
        if (FWFT == FIFO_MODE_FWFT) begin
            case (state)
                OUT_EMPTY: begin
                    if (wr_ok) begin
                        load_din  = 1'b1;
                        state_nxt = OUT_VALID;
                    end
                end
                OUT_VALID: begin
                    if (rd_ok) begin
                        if (!stor_empty) begin
                            load_mem = 1'b1;
                            rd_inc   = 1'b1;
                            mem_we   = wr_ok;
                        end else if (wr_ok) begin
                            load_din = 1'b1;
                        end else begin
                            state_nxt = OUT_EMPTY;
                        end
                    end else begin
                        mem_we = wr_ok;
                    end
                end
                default: state_nxt = OUT_EMPTY;
            endcase
        end else begin
            state_nxt = OUT_EMPTY;
            mem_we    = wr_ok;
            rd_inc    = rd_ok;
            load_mem  = rd_ok;
        end
    end

    // Storage array write port; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= din;
        end
    end

    // Output register: head word from storage or bypassed write data
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
        end else if (load_din) begin
            dout <= din;
        end else if (load_mem) begin
            dout <= mem[rd_ptr];
        end
    end

    // Occupancy: net change of accepted writes and reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ext.sv
// tb/tb_fifo_ext.sv - scoreboard bench for fifo_ext, three configurations driven by shared stimulus
module tb_fifo_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] a_dout, b_dout, c_dout;
    logic [2:0] a_count, b_count;
    logic [3:0] c_count;
    logic a_full, a_af, a_empty, a_ae, a_ovf, a_udf;
    logic b_full, b_af, b_empty, b_ae, b_ovf, b_udf;
    logic c_full, c_af, c_empty, c_ae, c_ovf, c_udf;

    fifo_ext #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(a_full), .almost_full(a_af),
        .rd_en(rd_en), .dout(a_dout), .empty(a_empty), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    fifo_ext #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(b_full), .almost_full(b_af),
        .rd_en(rd_en), .dout(b_dout), .empty(b_empty), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf)
    );

    fifo_ext #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(c_full), .almost_full(c_af),
        .rd_en(rd_en), .dout(c_dout), .empty(c_empty), .almost_empty(c_ae), .count(c_count),
        .overflow(c_ovf), .underflow(c_udf)
    );

    typedef struct packed {
        logic [7:0] dout;
        logic [3:0] cnt;
        logic       full;
        logic       af;
        logic       empty;
        logic       ae;
        logic       ovf;
        logic       udf;
    } st_t;

    st_t        exp_q [3][$];
    logic [7:0] mq    [3][$];
    logic [7:0] mdout [3];
    logic       movf  [3];
    logic       mudf  [3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int dep(input int i);
        return (i == 2) ? 8 : 5;
    endfunction

    function automatic int afth(input int i);
        return (i == 2) ? 6 : 3;
    endfunction

    function automatic st_t model_view(input int i);
        st_t s;
        int  n;
        n       = mq[i].size();
        s.dout  = mdout[i];
        s.cnt   = 4'(n);
        s.full  = (n == dep(i));
        s.af    = (n >= afth(i));
        s.empty = (n == 0);
        s.ae    = (n <= 2);
        s.ovf   = movf[i];
        s.udf   = mudf[i];
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mdout[i] = 8'h00;
            movf[i]  = 1'b0;
            mudf[i]  = 1'b0;
            exp_q[i].push_back(model_view(i));
        end
    endtask

    // Queue-level reference: accept against pre-cycle occupancy, pop then push
    task automatic model_step(input logic w, input logic r, input logic [7:0] d);
        int         n;
        logic [7:0] v;
        for (int i = 0; i < 3; i++) begin
            n = mq[i].size();
            if (w && n == dep(i)) movf[i] = 1'b1;
            if (r && n == 0)      mudf[i] = 1'b1;
            if (r && n > 0) begin
                v = mq[i].pop_front();
                if (i != 1) mdout[i] = v;
            end
            if (w && n < dep(i)) mq[i].push_back(d);
            if (i == 1 && mq[i].size() > 0) mdout[i] = mq[i][0];
            exp_q[i].push_back(model_view(i));
        end
    endtask

    task automatic cycle(input logic rn, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        rst   = rn;
        wr_en = w;
        rd_en = r;
        din   = d;
        if (!rn) model_reset();
        else     model_step(w, r, d);
    endtask

    function automatic st_t actual(input int i);
        st_t s;
        case (i)
            0: begin
                s.dout = a_dout; s.cnt = {1'b0, a_count}; s.full = a_full; s.af = a_af;
                s.empty = a_empty; s.ae = a_ae; s.ovf = a_ovf; s.udf = a_udf;
            end
            1: begin
                s.dout = b_dout; s.cnt = {1'b0, b_count}; s.full = b_full; s.af = b_af;
                s.empty = b_empty; s.ae = b_ae; s.ovf = b_ovf; s.udf = b_udf;
            end
            default: begin
                s.dout = c_dout; s.cnt = c_count; s.full = c_full; s.af = c_af;
                s.empty = c_empty; s.ae = c_ae; s.ovf = c_ovf; s.udf = c_udf;
            end
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t got 0x%0h expected 0x%0h", name, i, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per edge while stimulus is active
    always @(posedge clk) begin
        st_t e;
        st_t a;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (exp_q[i].size() > 0) begin
                e = exp_q[i].pop_front();
                a = actual(i);
                chk("dout",         i, int'(a.dout),  int'(e.dout));
                chk("count",        i, int'(a.cnt),   int'(e.cnt));
                chk("full",         i, int'(a.full),  int'(e.full));
                chk("almost_full",  i, int'(a.af),    int'(e.af));
                chk("empty",        i, int'(a.empty), int'(e.empty));
                chk("almost_empty", i, int'(a.ae),    int'(e.ae));
                chk("overflow",     i, int'(a.ovf),   int'(e.ovf));
                chk("underflow",    i, int'(a.udf),   int'(e.udf));
            end
        end
    end

    initial begin
        int wp;
        int rp;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h5A);

        // Fill to full, then overflow attempt
        for (int k = 1; k <= 5; k++) cycle(1'b1, 1'b1, 1'b0, 8'(17 * k));
        cycle(1'b1, 1'b1, 1'b0, 8'h66);

        // Drain with rd_en held, including underflow reads
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b1, 8'h00);

        // Pointer wrap
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hA0 + k));
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hB0 + k));
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, 8'h00);

        // Full with simultaneous write and read
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hC0 + k));
        cycle(1'b1, 1'b1, 1'b1, 8'hAA);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // FWFT bypass and read+write on a single word
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 8'h3C);
        cycle(1'b1, 1'b1, 1'b1, 8'h7E);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // Thresholds, then reset in the middle of a fill
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hD0 + k));
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 8'(8'hE0 + k));
        cycle(1'b0, 1'b1, 1'b0, 8'hEE);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // Randomised traffic with fill-heavy and drain-heavy phases
        for (int k = 0; k < 3000; k++) begin
            wp = ((k / 150) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            cycle(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
                  8'($urandom));
        end

        @(posedge clk);
        #3;
        for (int i = 0; i < 3; i++) chk("pending", i, exp_q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
